// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute path (port 0) and the
// address/branch helper (port 1). Optional grant locking via `ALU_ARB_LOCK_EN.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic              req0_lock,
`endif
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic              req1_lock,
`endif
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,

    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero
);

    // state  | meaning
    // IDLE   | no transaction in flight; granting requests
    // EXEC   | latched operands drive the ALU; result captured at edge
    // RESP   | result held for the owner until its resp_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic              rr_ptr;
    logic              owner;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              resp_accept;

`ifdef ALU_ARB_LOCK_EN
    logic              lock_held;
    logic              lock_q;
    logic              lock_in;
`endif

    always_comb begin
        elig0 = req0_valid;
        elig1 = req1_valid;
`ifdef ALU_ARB_LOCK_EN
        // While locked, only the previous owner may be granted.
        if (lock_held) begin
            if (owner) begin
                elig0 = 1'b0;
            end else begin
                elig1 = 1'b0;
            end
        end
`endif
        grant0 = elig0 && (!elig1 || !rr_ptr);
        grant1 = elig1 && (!elig0 ||  rr_ptr);
    end

    assign req0_ready = (state == S_IDLE) && grant0;
    assign req1_ready = (state == S_IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;

`ifdef ALU_ARB_LOCK_EN
    assign lock_in = req1_ready ? req1_lock : req0_lock;
`endif

    assign resp_accept = (state == S_RESP) && (owner ? resp1_ready : resp0_ready);

    assign resp0_valid  = (state == S_RESP) && !owner;
    assign resp1_valid  = (state == S_RESP) &&  owner;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;

    // The ALU sees quiet inputs except while a transaction executes.
    assign alu_ctrl = (state == S_EXEC) ? ctrl_q : '0;
    assign alu_a    = (state == S_EXEC) ? a_q    : '0;
    assign alu_b    = (state == S_EXEC) ? b_q    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_held <= 1'b0;
            lock_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner  <= req1_ready;
                        ctrl_q <= req1_ready ? req1_ctrl : req0_ctrl;
                        a_q    <= req1_ready ? req1_a    : req0_a;
                        b_q    <= req1_ready ? req1_b    : req0_b;
`ifdef ALU_ARB_LOCK_EN
                        lock_q <= lock_in;
`endif
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= alu_out;
                    zero_q   <= alu_zero;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (resp_accept) begin
                        state <= S_IDLE;
`ifdef ALU_ARB_LOCK_EN
                        lock_held <= lock_q;
                        if (!lock_q) begin
                            rr_ptr <= ~owner;
                        end
`else
                        rr_ptr <= ~owner;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model. Lock scenario under `ALU_ARB_LOCK_EN.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
    logic [3:0]  req0_ctrl, req1_ctrl, alu_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
`ifdef ALU_ARB_LOCK_EN
    logic        req0_lock, req1_lock;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(req0_lock),
`endif
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
`ifdef ALU_ARB_LOCK_EN
        .req1_lock(req1_lock),
`endif
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_out  = ref_alu(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_out == 32'd0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0; resp0_ready = 0;
        req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0; resp1_ready = 0;
`ifdef ALU_ARB_LOCK_EN
        req0_lock = 0; req1_lock = 0;
`endif
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks += 9;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        if (resp0_valid !== 1'b0) begin errors++; $display("FAIL reset_resp0_valid got=%b exp=0", resp0_valid); end
        if (resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp1_valid got=%b exp=0", resp1_valid); end
        if (alu_ctrl !== 4'd0) begin errors++; $display("FAIL reset_alu_ctrl got=%h exp=0", alu_ctrl); end
        if (alu_a !== 32'd0) begin errors++; $display("FAIL reset_alu_a got=%h exp=0", alu_a); end
        if (alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_b got=%h exp=0", alu_b); end
        if (resp0_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", resp0_result); end
        if (resp0_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", resp0_zero); end
    endtask

    task automatic test_basic_add;
        do_reset();
        req0_valid = 1; req0_ctrl = 4'b0010; req0_a = 5; req0_b = 7; resp0_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_accept got=%b exp=1", req0_ready); end
        tick();
        req0_valid = 0;
        #1;
        checks += 4;
        if (resp0_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got=%b exp=0", resp0_valid); end
        if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL add_alu_ctrl got=%h exp=2", alu_ctrl); end
        if (alu_a !== 32'd5) begin errors++; $display("FAIL add_alu_a got=%0d exp=5", alu_a); end
        if (alu_b !== 32'd7) begin errors++; $display("FAIL add_alu_b got=%0d exp=7", alu_b); end
        tick();
        #1;
        checks += 3;
        if (resp0_valid !== 1'b1) begin errors++; $display("FAIL add_resp_valid got=%b exp=1", resp0_valid); end
        if (resp0_result !== 32'd12) begin errors++; $display("FAIL add_result got=%0d exp=12", resp0_result); end
        if (resp0_zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b exp=0", resp0_zero); end
        tick();
        #1;
        checks++;
        if (resp0_valid !== 1'b0) begin errors++; $display("FAIL add_resp_drop got=%b exp=0", resp0_valid); end
    endtask

    task automatic test_back_to_back;
        logic        w;
        logic [31:0] er;
        do_reset();
        req0_valid = 1; req0_ctrl = 4'b0110; req0_a = 9; req0_b = 9;
        req1_valid = 1; req1_ctrl = 4'b0001; req1_a = 32'hF0; req1_b = 32'h0F;
        resp0_ready = 1; resp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            w  = i[0];
            er = w ? 32'hFF : 32'd0;
            #1;
            checks += 2;
            if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_grant op=%0d got=%b%b exp_port=%0d", i, req1_ready, req0_ready, w);
            end
            tick();
            #1;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                errors++; $display("FAIL b2b_exec_ready op=%0d got=%b%b exp=00", i, req1_ready, req0_ready);
            end
            tick();
            #1;
            checks += 3;
            if ({resp1_valid, resp0_valid} !== (w ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_resp_valid op=%0d got=%b%b exp_port=%0d", i, resp1_valid, resp0_valid, w);
            end
            if ((w ? resp1_result : resp0_result) !== er) begin
                errors++; $display("FAIL b2b_result op=%0d got=%h exp=%h", i, w ? resp1_result : resp0_result, er);
            end
            if ((w ? resp1_zero : resp0_zero) !== !w) begin
                errors++; $display("FAIL b2b_zero op=%0d got=%b exp=%b", i, w ? resp1_zero : resp0_zero, !w);
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        req1_valid = 1; req1_ctrl = 4'b0010; req1_a = 100; req1_b = 23;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got=%b exp=1", req1_ready); end
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_ctrl = 4'b0010; req0_a = 1; req0_b = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks += 4;
            if (resp1_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, resp1_valid); end
            if (resp1_result !== 32'd123) begin errors++; $display("FAIL bp_result cyc=%0d got=%0d exp=123", i, resp1_result); end
            if (resp1_zero !== 1'b0) begin errors++; $display("FAIL bp_zero cyc=%0d got=%b exp=0", i, resp1_zero); end
            if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready cyc=%0d got=%b exp=0", i, req0_ready); end
            tick();
        end
        resp1_ready = 1;
        #1;
        checks++;
        if (resp1_valid !== 1'b1) begin errors++; $display("FAIL bp_final_valid got=%b exp=1", resp1_valid); end
        tick();
        #1;
        checks += 2;
        if (resp1_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", resp1_valid); end
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_next_grant got=%b exp=1", req0_ready); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        // Complete one port 0 op so port 1 is favoured, then reset mid-flight.
        req0_valid = 1; req0_ctrl = 4'b0010; req0_a = 2; req0_b = 2; resp0_ready = 1;
        tick();
        req0_valid = 0;
        tick();
        tick();
        req0_valid = 1; req1_valid = 1; req1_ctrl = 4'b0010; req1_a = 4; req1_b = 4;
        resp1_ready = 1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++; $display("FAIL rstmid_pre_grant got=%b%b exp=10", req1_ready, req0_ready);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks += 5;
        if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready got=%b%b exp=00", req1_ready, req0_ready); end
        if ({resp1_valid, resp0_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_valid got=%b%b exp=00", resp1_valid, resp0_valid); end
        if (alu_a !== 32'd0) begin errors++; $display("FAIL rstmid_alu_a got=%h exp=0", alu_a); end
        if (resp1_result !== 32'd0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", resp1_result); end
        if (alu_ctrl !== 4'd0) begin errors++; $display("FAIL rstmid_alu_ctrl got=%h exp=0", alu_ctrl); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resp1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_resp cyc=%0d got=%b exp=0", i, resp1_valid); end
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL rstmid_post_grant got=%b%b exp=01", req1_ready, req0_ready);
        end
    endtask

    task automatic test_bad_ctrl;
        do_reset();
        req0_valid = 1; req0_ctrl = 4'b1111; req0_a = 3; req0_b = 3; resp0_ready = 1;
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if (alu_ctrl !== 4'b1111) begin errors++; $display("FAIL bad_ctrl_pass got=%h exp=f", alu_ctrl); end
        tick();
        #1;
        checks += 3;
        if (resp0_valid !== 1'b1) begin errors++; $display("FAIL bad_ctrl_valid got=%b exp=1", resp0_valid); end
        if (resp0_result !== 32'd0) begin errors++; $display("FAIL bad_ctrl_result got=%h exp=0", resp0_result); end
        if (resp0_zero !== 1'b1) begin errors++; $display("FAIL bad_ctrl_zero got=%b exp=1", resp0_zero); end
        tick();
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock;
        do_reset();
        resp0_ready = 1; resp1_ready = 1;
        req0_ctrl = 4'b0010; req0_a = 50; req0_b = 50;
        for (int k = 0; k < 3; k++) begin
            req1_valid = 1; req1_ctrl = 4'b0010; req1_a = k; req1_b = 10; req1_lock = (k < 2);
            #1;
            checks += 2;
            if ({req1_ready, req0_ready} !== 2'b10) begin
                errors++; $display("FAIL lock_grant op=%0d got=%b%b exp=10", k, req1_ready, req0_ready);
            end
            tick();
            req0_valid = 1;
            tick();
            #1;
            if (resp1_result !== 32'(k + 10)) begin
                errors++; $display("FAIL lock_result op=%0d got=%0d exp=%0d", k, resp1_result, k + 10);
            end
            tick();
        end
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL lock_release got=%b%b exp=01", req1_ready, req0_ready);
        end
    endtask
`endif

    task automatic test_random;
        bit          inflight = 0;
        bit          own = 0;
        bit          pref = 0;
        int          acc = 0;
        logic [3:0]  ec;
        logic [31:0] ea, eb, er;
        bit          e_r0, e_r1, e_v0, e_v1;
        logic [3:0]  codes [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1010};
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_ctrl  = codes[$urandom_range(0, 4)];
            req1_ctrl  = codes[$urandom_range(0, 4)];
            req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_r0 = !inflight && req0_valid && (!req1_valid || pref == 1'b0);
            e_r1 = !inflight && req1_valid && (!req0_valid || pref == 1'b1);
            e_v0 = inflight && !own && (cyc >= acc + 2);
            e_v1 = inflight &&  own && (cyc >= acc + 2);
            checks += 4;
            if (req0_ready !== e_r0) begin errors++; $display("FAIL rnd_ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, e_r0); end
            if (req1_ready !== e_r1) begin errors++; $display("FAIL rnd_ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, e_r1); end
            if (resp0_valid !== e_v0) begin errors++; $display("FAIL rnd_valid0 cyc=%0d got=%b exp=%b", cyc, resp0_valid, e_v0); end
            if (resp1_valid !== e_v1) begin errors++; $display("FAIL rnd_valid1 cyc=%0d got=%b exp=%b", cyc, resp1_valid, e_v1); end
            if (inflight && cyc == acc + 1) begin
                checks++;
                if ({alu_ctrl, alu_a, alu_b} !== {ec, ea, eb}) begin
                    errors++; $display("FAIL rnd_alu_in cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, alu_ctrl, alu_a, alu_b, ec, ea, eb);
                end
            end
            if (e_v0 || e_v1) begin
                checks += 2;
                if ((own ? resp1_result : resp0_result) !== er) begin
                    errors++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, own ? resp1_result : resp0_result, er);
                end
                if ((own ? resp1_zero : resp0_zero) !== (er == 32'd0)) begin
                    errors++; $display("FAIL rnd_zero cyc=%0d got=%b exp=%b", cyc, own ? resp1_zero : resp0_zero, er == 32'd0);
                end
            end
            if (e_r0 || e_r1) begin
                inflight = 1; own = e_r1; acc = cyc;
                ec = e_r1 ? req1_ctrl : req0_ctrl;
                ea = e_r1 ? req1_a : req0_a;
                eb = e_r1 ? req1_b : req0_b;
                er = ref_alu(ec, ea, eb);
            end else if ((e_v0 && resp0_ready) || (e_v1 && resp1_ready)) begin
                inflight = 0;
                pref = ~own;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_bad_ctrl();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
